// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory access controller.
// Access sizes, FSM states and the big-endian byte-lane helper.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WSTORE,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_ERR,
    ST_RESP
  } state_e;

  // Big-endian: byte address 0 lives in bits [31:24].
  function automatic logic [1:0] byte_lane(input logic [1:0] off);
    return 2'd3 - off;
  endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Sub-word lane handling: extract/extend for loads,
// lane insertion into an existing word for stores.
module dmem_lane_merge
  import dmem_ctrl_pkg::*;
(
  input  size_e       size,
  input  logic        sgn,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [1:0]  lane;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    lane    = byte_lane(off);
    b       = word[{lane, 3'b000} +: 8];
    h       = off[1] ? word[15:0] : word[31:16];
    ld_data = word;
    st_word = wdata;
    unique case (size)
      SZ_BYTE: begin
        ld_data = {{24{sgn & b[7]}}, b};
        st_word = word;
        st_word[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ld_data = {{16{sgn & h[15]}}, h};
        st_word = off[1] ? {word[31:16], wdata[15:0]}
                         : {wdata[15:0], word[15:0]};
      end
      default: begin
        ld_data = word;
        st_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// CPU load/store sequencer onto a word-only data memory:
// direct word writes, read-modify-write for sub-word stores.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);

  localparam logic [29:0] WORD_LIM = 30'(MEM_WORDS);

  state_e      state_q, state_d;
  logic        write_q, write_d;
  size_e       size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] old_q, old_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        req_err;
  logic [31:0] merge_word;
  logic [31:0] ld_data;
  logic [31:0] st_word;

  assign accept = req_valid & (state_q == ST_IDLE);

  always_comb begin
    req_err = (req_size == SZ_BAD)
            | ((req_size == SZ_HALF) & req_addr[0])
            | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
            | (req_addr[31:2] >= WORD_LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          unique case (1'b1)
            req_err:
              state_d = ST_ERR;
            !req_err & !req_write:
              state_d = ST_LOAD;
            !req_err & req_write & (req_size == SZ_WORD):
              state_d = ST_WSTORE;
            !req_err & req_write & (req_size != SZ_WORD):
              state_d = ST_RMW_RD;
          endcase
        end
      end
      ST_LOAD, ST_WSTORE, ST_RMW_WR, ST_ERR:
        state_d = ST_RESP;
      ST_RMW_RD:
        state_d = ST_RMW_WR;
      ST_RESP:
        state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready      = (state_q == ST_IDLE) & rst_n;
    mem_address    = {addr_q[31:2], 2'b00};
    mem_read       = (state_q == ST_LOAD) | (state_q == ST_RMW_RD);
    mem_write      = (state_q == ST_WSTORE) | (state_q == ST_RMW_WR);
    mem_write_data = '0;
    if (state_q == ST_WSTORE) mem_write_data = wdata_q;
    if (state_q == ST_RMW_WR) mem_write_data = st_word;
    resp_valid     = (state_q == ST_RESP);
    resp_err       = (state_q == ST_RESP) & err_q;
    resp_rdata     = rdata_q;
  end

  // Loads extract from live memory data; stores merge into the latched word.
  assign merge_word = write_q ? old_q : mem_read_data;

  dmem_lane_merge u_merge (
    .size    (size_q),
    .sgn     (signed_q),
    .off     (addr_q[1:0]),
    .word    (merge_word),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  always_comb begin
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    old_d    = old_q;
    rdata_d  = rdata_q;
    if (accept) begin
      write_d  = req_write;
      size_d   = size_e'(req_size);
      signed_d = req_signed;
      addr_d   = req_addr;
      wdata_d  = req_wdata;
      err_d    = req_err;
      rdata_d  = '0;
    end
    if (state_q == ST_LOAD)   rdata_d = ld_data;
    if (state_q == ST_RMW_RD) old_d   = mem_read_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q  <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      old_q    <= '0;
      rdata_q  <= '0;
    end else begin
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      old_q    <= old_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural
// word memory and hand-computed expected values.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.MEM_WORDS(4096)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  logic [31:0] mem [0:4095];
  logic        bd_we;
  logic [11:0] bd_idx;
  logic [31:0] bd_data;

  assign mem_read_data = mem[mem_address[13:2]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_address[13:2]] <= mem_write_data;
    else if (bd_we) mem[bd_idx] <= bd_data;
  end

  int total = 0;
  int bad = 0;

  int          r_lat;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_rd;
  logic        r_wr;
  logic [31:0] r_wd;
  logic        r_both = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] idx, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic run_req(input logic w, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a,
                         input logic [31:0] d);
    int n;
    logic got;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz;
    req_signed = sg; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("acc_tmo", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_wdata = 32'h0;
    r_lat = 1; r_rd = 1'b0; r_wr = 1'b0; r_wd = '0;
    r_rdata = 'x; r_err = 1'bx;
    got = 1'b0; n = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      if (mem_read) r_rd = 1'b1;
      if (mem_write) begin
        r_wr = 1'b1;
        r_wd = mem_write_data;
      end
      if (mem_read && mem_write) r_both = 1'b1;
      if (resp_valid) begin
        got = 1'b1;
        r_rdata = resp_rdata;
        r_err = resp_err;
      end else begin
        @(posedge clk);
        r_lat++;
        n++;
      end
    end
    check("resp_tmo", {31'd0, got}, 32'd1);
  endtask

  logic [1:0]  e_sz [5];
  logic [31:0] e_ad [5];
  logic        e_wr [5];
  int acc;
  int nresp;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    bd_we = 1'b0; bd_idx = '0; bd_data = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rvalid", {31'd0, resp_valid}, 32'd0);
    check("rst_rerr", {31'd0, resp_err}, 32'd0);
    check("rst_mwr", {31'd0, mem_write}, 32'd0);
    check("rst_mrd", {31'd0, mem_read}, 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_ready", {31'd0, req_ready}, 32'd1);

    // word store then word load
    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    check("sw_lat", r_lat, 32'd2);
    check("sw_err", {31'd0, r_err}, 32'd0);
    check("sw_rd", {31'd0, r_rd}, 32'd0);
    check("sw_wd", r_wd, 32'hDEADBEEF);
    check("sw_mem", mem[4], 32'hDEADBEEF);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw_lat", r_lat, 32'd2);
    check("lw_data", r_rdata, 32'hDEADBEEF);
    check("lw_err", {31'd0, r_err}, 32'd0);

    // sub-word stores via read-modify-write
    poke(12'd1, 32'h11223344);
    run_req(1'b1, 2'b00, 1'b0, 32'h6, 32'hFFFFFFAA);
    check("sb_lat", r_lat, 32'd3);
    check("sb_rd", {31'd0, r_rd}, 32'd1);
    check("sb_wd", r_wd, 32'h1122AA44);
    check("sb_mem", mem[1], 32'h1122AA44);
    check("sb_rdata", r_rdata, 32'h0);
    check("sb_err", {31'd0, r_err}, 32'd0);
    run_req(1'b1, 2'b01, 1'b0, 32'h4, 32'h1234BEEF);
    check("sh_lat", r_lat, 32'd3);
    check("sh_mem", mem[1], 32'hBEEFAA44);

    // sub-word loads
    poke(12'd0, 32'h80FF7F01);
    run_req(1'b0, 2'b00, 1'b1, 32'h0, 32'h0);
    check("lb_0", r_rdata, 32'hFFFFFF80);
    run_req(1'b0, 2'b00, 1'b0, 32'h1, 32'h0);
    check("lbu_1", r_rdata, 32'h000000FF);
    run_req(1'b0, 2'b00, 1'b1, 32'h3, 32'h0);
    check("lb_3", r_rdata, 32'h00000001);
    run_req(1'b0, 2'b01, 1'b1, 32'h2, 32'h0);
    check("lh_2", r_rdata, 32'h00007F01);
    run_req(1'b0, 2'b01, 1'b1, 32'h0, 32'h0);
    check("lh_0", r_rdata, 32'hFFFF80FF);
    check("lh_lat", r_lat, 32'd2);
    run_req(1'b0, 2'b01, 1'b0, 32'h0, 32'h0);
    check("lhu_0", r_rdata, 32'h000080FF);

    // error cases
    e_sz[0] = 2'b10; e_ad[0] = 32'h2;    e_wr[0] = 1'b0;
    e_sz[1] = 2'b01; e_ad[1] = 32'h3;    e_wr[1] = 1'b0;
    e_sz[2] = 2'b11; e_ad[2] = 32'h0;    e_wr[2] = 1'b0;
    e_sz[3] = 2'b10; e_ad[3] = 32'h4000; e_wr[3] = 1'b0;
    e_sz[4] = 2'b10; e_ad[4] = 32'h4000; e_wr[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_req(e_wr[i], e_sz[i], 1'b0, e_ad[i], 32'h5A5A5A5A);
      check($sformatf("err%0d_err", i), {31'd0, r_err}, 32'd1);
      check($sformatf("err%0d_lat", i), r_lat, 32'd2);
      check($sformatf("err%0d_mem", i), {30'd0, r_rd, r_wr}, 32'd0);
      check($sformatf("err%0d_rdata", i), r_rdata, 32'h0);
    end
    check("err_nowrite", mem[0], 32'h80FF7F01);

    // async reset during RMW_WR aborts the write
    poke(12'd5, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h14; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 check("ab_wr_pre", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1 check("ab_wr_drop", {31'd0, mem_write}, 32'd0);
    @(posedge clk);
    #1;
    check("ab_mem", mem[5], 32'hCAFEF00D);
    check("ab_rvalid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ab_ready", {31'd0, req_ready}, 32'd1);
    check("ab_rvalid2", {31'd0, resp_valid}, 32'd0);
    run_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    check("ab_lw", r_rdata, 32'hCAFEF00D);

    // back-to-back with req_valid held high
    acc = 0; nresp = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10;
    req_signed = 1'b0; req_addr = 32'h10;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (req_ready) acc++;
      if (resp_valid) begin
        nresp++;
        check("b2b_data", resp_rdata, 32'hDEADBEEF);
      end
      if (req_ready && resp_valid) r_both = 1'b1;
    end
    req_valid = 1'b0;
    check("b2b_acc", acc, 32'd4);
    check("b2b_resp", nresp, 32'd4);
    @(negedge clk);
    check("b2b_idle", {31'd0, req_ready}, 32'd1);
    check("rd_wr_excl", {31'd0, r_both}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
